irq_trap_ctrl: RTL and testbench

//  Machine-mode trap sequencer downstream of the CSR file. Consumes CSR state
//  (mstatus.MIE/MPIE, mie.MEIE, mepc) and the EXE-stage instruction,

---
 rtl/irq_trap_ctrl_if.sv | 26 ++
 rtl/irq_trap_ctrl.sv | 110 +++++++++++
 tb/tb_irq_trap_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_trap_ctrl_if.sv
// irq_trap_ctrl_if: signal bundle between pipeline/CSR file and the trap sequencer
// Pipeline/CSR side (master) drives:
//   interrupt, stall, exe_valid, exe_pc, exe_mret, exe_wfi,
//   csr_mstatus_mie, csr_mstatus_mpie, csr_mie_meie, csr_mepc
// Sequencer side (slave) drives:
//   mip_meip, redirect, redirect_pc, flush, mepc_we, mepc_wdata,
//   mstatus_we, mstatus_mie_nx, mstatus_mpie_nx, sleep
interface irq_trap_ctrl_if #(parameter int DATA_W = 32);
  logic interrupt, stall, exe_valid, exe_mret, exe_wfi;
  logic csr_mstatus_mie, csr_mstatus_mpie, csr_mie_meie;
  logic [DATA_W-1:0] exe_pc, csr_mepc, redirect_pc, mepc_wdata;
  logic mip_meip, redirect, flush, mepc_we, mstatus_we;
  logic mstatus_mie_nx, mstatus_mpie_nx, sleep;
  modport master (
    output interrupt, stall, exe_valid, exe_pc, exe_mret, exe_wfi,
           csr_mstatus_mie, csr_mstatus_mpie, csr_mie_meie, csr_mepc,
    input  mip_meip, redirect, redirect_pc, flush, mepc_we, mepc_wdata,
           mstatus_we, mstatus_mie_nx, mstatus_mpie_nx, sleep
  );
  modport slave (
    input  interrupt, stall, exe_valid, exe_pc, exe_mret, exe_wfi,
           csr_mstatus_mie, csr_mstatus_mpie, csr_mie_meie, csr_mepc,
    output mip_meip, redirect, redirect_pc, flush, mepc_we, mepc_wdata,
           mstatus_we, mstatus_mie_nx, mstatus_mpie_nx, sleep
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: machine-mode trap sequencer for interrupt entry, MRET and WFI
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  irq_trap_ctrl_if.slave: EXE instruction + CSR state in,
//        synchronised mip_meip, PC redirect/flush and CSR update pulses out
// All outputs are registered: a decision on cycle N is visible on cycle N+1.
module irq_trap_ctrl #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] MTVEC_BASE = 32'h1000_0000,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  irq_trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENTER, RETURN, SLEEP} state_t;
  typedef struct packed {
    logic redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic flush;
    logic mepc_we;
    logic [DATA_W-1:0] mepc_wdata;
    logic mstatus_we;
    logic mie_nx;
    logic mpie_nx;
    logic sleep;
  } out_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DATA_W-1:0] epc_q, epc_d;
  out_t out_q, out_d;
  logic pending, take, decide;
  assign pending = sync_q[SYNC_STAGES-1] & bus.csr_mie_meie;
  assign take = pending & bus.csr_mstatus_mie;
  // the EXE instruction is being killed while our own flush is visible
  assign decide = !bus.stall & bus.exe_valid & !out_q.flush;
  always_comb begin
    state_d = state_q;
    epc_d = epc_q;
    out_d = '0;
    case (state_q)
      IDLE: if (decide) begin
        if (take) begin
          state_d = ENTER;
          epc_d = bus.exe_pc;
        end else if (bus.exe_mret) begin
          state_d = RETURN;
          out_d.redirect = 1'b1;
          out_d.redirect_pc = bus.csr_mepc;
          out_d.flush = 1'b1;
          out_d.mstatus_we = 1'b1;
          out_d.mie_nx = bus.csr_mstatus_mpie;
          out_d.mpie_nx = 1'b1;
        end else if (bus.exe_wfi && !pending) begin
          state_d = SLEEP;
          epc_d = bus.exe_pc + DATA_W'(4);
          out_d.sleep = 1'b1;
        end
      end
      ENTER, RETURN: if (bus.stall) begin
        out_d = out_q;
        out_d.mepc_we = 1'b0;
        out_d.mstatus_we = 1'b0;
      end else state_d = IDLE;
      SLEEP: if (!pending) out_d.sleep = 1'b1;
      else if (take) state_d = ENTER;
      else begin
        state_d = IDLE;
        out_d.redirect = 1'b1;
        out_d.redirect_pc = epc_q;
        out_d.flush = 1'b1;
      end
    endcase
    // first ENTER cycle, whether from IDLE or waking from SLEEP
    if (state_d == ENTER && state_q != ENTER) begin
      out_d = '0;
      out_d.redirect = 1'b1;
      out_d.redirect_pc = MTVEC_BASE;
      out_d.flush = 1'b1;
      out_d.mepc_we = 1'b1;
      out_d.mepc_wdata = epc_d;
      out_d.mstatus_we = 1'b1;
      out_d.mpie_nx = bus.csr_mstatus_mie;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      epc_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.interrupt};
      epc_q <= epc_d;
      out_q <= out_d;
    end
  end
  assign bus.mip_meip = sync_q[SYNC_STAGES-1];
  assign bus.redirect = out_q.redirect;
  assign bus.redirect_pc = out_q.redirect_pc;
  assign bus.flush = out_q.flush;
  assign bus.mepc_we = out_q.mepc_we;
  assign bus.mepc_wdata = out_q.mepc_wdata;
  assign bus.mstatus_we = out_q.mstatus_we;
  assign bus.mstatus_mie_nx = out_q.mie_nx;
  assign bus.mstatus_mpie_nx = out_q.mpie_nx;
  assign bus.sleep = out_q.sleep;
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// tb_irq_trap_ctrl: directed self-checking bench for irq_trap_ctrl
module tb_irq_trap_ctrl;
  localparam logic [31:0] MTVEC = 32'h1000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] rcnt, wcnt;
  irq_trap_ctrl_if bus ();
  irq_trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    bus.interrupt = 1'b0;
    bus.stall = 1'b0;
    bus.exe_valid = 1'b0;
    bus.exe_pc = '0;
    bus.exe_mret = 1'b0;
    bus.exe_wfi = 1'b0;
    bus.csr_mstatus_mie = 1'b0;
    bus.csr_mstatus_mpie = 1'b0;
    bus.csr_mie_meie = 1'b0;
    bus.csr_mepc = '0;
    tick(2);
    chkb("rst_redirect", bus.redirect, 1'b0);
    chkb("rst_flush", bus.flush, 1'b0);
    chkb("rst_sleep", bus.sleep, 1'b0);
    chkb("rst_mip", bus.mip_meip, 1'b0);
    chkb("rst_mepc_we", bus.mepc_we, 1'b0);
    rst = 1'b0;
    // T1: interrupt entry
    bus.csr_mstatus_mie = 1'b1;
    bus.csr_mie_meie = 1'b1;
    bus.exe_pc = 32'h100;
    bus.exe_valid = 1'b1;
    bus.interrupt = 1'b1;
    tick;
    chkb("t1_mip_after_1clk", bus.mip_meip, 1'b0);
    tick;
    chkb("t1_mip_after_2clk", bus.mip_meip, 1'b1);
    chkb("t1_no_redirect_yet", bus.redirect, 1'b0);
    tick;
    chkb("t1_redirect", bus.redirect, 1'b1);
    chk("t1_redirect_pc", bus.redirect_pc, MTVEC);
    chkb("t1_flush", bus.flush, 1'b1);
    chkb("t1_mepc_we", bus.mepc_we, 1'b1);
    chk("t1_mepc_wdata", bus.mepc_wdata, 32'h100);
    chkb("t1_mstatus_we", bus.mstatus_we, 1'b1);
    chkb("t1_mie_nx", bus.mstatus_mie_nx, 1'b0);
    chkb("t1_mpie_nx", bus.mstatus_mpie_nx, 1'b1);
    bus.exe_valid = 1'b0;
    bus.interrupt = 1'b0;
    tick;
    chkb("t1_exit_redirect", bus.redirect, 1'b0);
    chkb("t1_exit_mepc_we", bus.mepc_we, 1'b0);
    tick(2);
    chkb("t1_mip_clear", bus.mip_meip, 1'b0);
    // glitch between clock edges is never sampled
    bus.exe_pc = 32'h140;
    bus.exe_valid = 1'b1;
    bus.interrupt = 1'b1;
    #2;
    bus.interrupt = 1'b0;
    tick(4);
    chkb("glitch_mip", bus.mip_meip, 1'b0);
    chkb("glitch_redirect", bus.redirect, 1'b0);
    bus.exe_valid = 1'b0;
    // T2: pending but masked by MIE, then unmasked
    bus.csr_mstatus_mie = 1'b0;
    bus.exe_pc = 32'h180;
    bus.exe_valid = 1'b1;
    bus.interrupt = 1'b1;
    tick(2);
    chkb("t2_mip", bus.mip_meip, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chkb("t2_masked_no_redirect", bus.redirect, 1'b0);
    end
    bus.csr_mstatus_mie = 1'b1;
    tick;
    chkb("t2_redirect", bus.redirect, 1'b1);
    chk("t2_mepc_wdata", bus.mepc_wdata, 32'h180);
    chkb("t2_mpie_nx", bus.mstatus_mpie_nx, 1'b1);
    bus.exe_valid = 1'b0;
    bus.interrupt = 1'b0;
    tick;
    chkb("t2_exit", bus.redirect, 1'b0);
    tick(2);
    // T3: MRET
    bus.csr_mstatus_mie = 1'b0;
    bus.csr_mstatus_mpie = 1'b1;
    bus.csr_mepc = 32'h204;
    bus.exe_pc = 32'h200;
    bus.exe_mret = 1'b1;
    bus.exe_valid = 1'b1;
    tick;
    chkb("t3_redirect", bus.redirect, 1'b1);
    chk("t3_redirect_pc", bus.redirect_pc, 32'h204);
    chkb("t3_flush", bus.flush, 1'b1);
    chkb("t3_mstatus_we", bus.mstatus_we, 1'b1);
    chkb("t3_mie_nx", bus.mstatus_mie_nx, 1'b1);
    chkb("t3_mpie_nx", bus.mstatus_mpie_nx, 1'b1);
    chkb("t3_no_mepc_we", bus.mepc_we, 1'b0);
    bus.exe_valid = 1'b0;
    bus.exe_mret = 1'b0;
    tick;
    chkb("t3_exit", bus.redirect, 1'b0);
    chkb("t3_mstatus_we_drop", bus.mstatus_we, 1'b0);
    // T4a: WFI, wake into ENTER
    bus.csr_mstatus_mie = 1'b1;
    bus.exe_pc = 32'h300;
    bus.exe_wfi = 1'b1;
    bus.exe_valid = 1'b1;
    tick;
    chkb("t4_sleep", bus.sleep, 1'b1);
    chkb("t4_sleep_no_redirect", bus.redirect, 1'b0);
    bus.exe_valid = 1'b0;
    bus.exe_wfi = 1'b0;
    bus.stall = 1'b1;
    tick;
    chkb("t4_sleep_under_stall", bus.sleep, 1'b1);
    bus.stall = 1'b0;
    bus.interrupt = 1'b1;
    tick(2);
    chkb("t4_sleep_until_decision", bus.sleep, 1'b1);
    tick;
    chkb("t4_wake_sleep", bus.sleep, 1'b0);
    chkb("t4_wake_redirect", bus.redirect, 1'b1);
    chk("t4_wake_redirect_pc", bus.redirect_pc, MTVEC);
    chkb("t4_wake_mepc_we", bus.mepc_we, 1'b1);
    chk("t4_wake_mepc_wdata", bus.mepc_wdata, 32'h304);
    bus.interrupt = 1'b0;
    tick;
    chkb("t4_exit", bus.redirect, 1'b0);
    tick(2);
    // T4b: WFI, wake with MIE=0 resumes after the WFI
    bus.csr_mstatus_mie = 1'b0;
    bus.exe_wfi = 1'b1;
    bus.exe_valid = 1'b1;
    tick;
    chkb("t4b_sleep", bus.sleep, 1'b1);
    bus.exe_valid = 1'b0;
    bus.exe_wfi = 1'b0;
    bus.interrupt = 1'b1;
    tick(3);
    chkb("t4b_redirect", bus.redirect, 1'b1);
    chk("t4b_redirect_pc", bus.redirect_pc, 32'h304);
    chkb("t4b_flush", bus.flush, 1'b1);
    chkb("t4b_no_mepc_we", bus.mepc_we, 1'b0);
    chkb("t4b_sleep_drop", bus.sleep, 1'b0);
    bus.interrupt = 1'b0;
    tick;
    chkb("t4b_redirect_1cyc", bus.redirect, 1'b0);
    chkb("t4b_flush_1cyc", bus.flush, 1'b0);
    tick(2);
    // T5: take beats MRET; stall holds ENTER
    bus.csr_mstatus_mie = 1'b1;
    bus.interrupt = 1'b1;
    tick(2);
    bus.exe_pc = 32'h500;
    bus.exe_mret = 1'b1;
    bus.exe_valid = 1'b1;
    tick;
    chk("t5_priority_pc", bus.redirect_pc, MTVEC);
    chk("t5_mepc_wdata", bus.mepc_wdata, 32'h500);
    rcnt = 32'(bus.redirect);
    wcnt = 32'(bus.mepc_we);
    bus.exe_valid = 1'b0;
    bus.exe_mret = 1'b0;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      rcnt = rcnt + 32'(bus.redirect);
      wcnt = wcnt + 32'(bus.mepc_we);
    end
    chk("t5_held_pc", bus.redirect_pc, MTVEC);
    bus.stall = 1'b0;
    tick;
    rcnt = rcnt + 32'(bus.redirect);
    wcnt = wcnt + 32'(bus.mepc_we);
    chk("t5_redirect_cycles", rcnt, 32'd4);
    chk("t5_mepc_we_pulses", wcnt, 32'd1);
    chkb("t5_exit", bus.redirect, 1'b0);
    bus.interrupt = 1'b0;
    tick(3);
    // T6a: asynchronous reset while in ENTER
    bus.exe_pc = 32'h600;
    bus.exe_valid = 1'b1;
    bus.interrupt = 1'b1;
    tick(3);
    chkb("t6_in_enter", bus.redirect, 1'b1);
    bus.exe_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chkb("t6_rst_redirect", bus.redirect, 1'b0);
    chkb("t6_rst_flush", bus.flush, 1'b0);
    chkb("t6_rst_mepc_we", bus.mepc_we, 1'b0);
    chkb("t6_rst_mip", bus.mip_meip, 1'b0);
    bus.interrupt = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chkb("t6_idle_after_rst", bus.redirect, 1'b0);
    // T6b: asynchronous reset while sleeping
    bus.exe_pc = 32'h700;
    bus.exe_wfi = 1'b1;
    bus.exe_valid = 1'b1;
    tick;
    chkb("t6b_sleep", bus.sleep, 1'b1);
    bus.exe_valid = 1'b0;
    bus.exe_wfi = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chkb("t6b_rst_sleep", bus.sleep, 1'b0);
    tick;
    rst = 1'b0;
    tick;
    chkb("t6b_idle_after_rst", bus.sleep, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
